// File: rtl/retospect_neuron_cell.sv
// retospect_neuron_cell
// N-dendrite leaky integrate-and-fire neuron for the cell array. Weights,
// firing threshold, decay-clock select and refractory period load from a
// serial bitstream chain, and all active dendrites are summed each cycle
// with saturation.
//
// Ports
//   clk        clock, all state on posedge
//   reset      synchronous active-high; clears configuration and run state
//   reset_nn   network reset; clears run state only, configuration retained
//   config_en  1 = shift the bitstream chain, 0 = run
//   bs_in      bitstream serial in
//   bs_out     bitstream serial out (LSB of the refractory field)
//   clockbus   decay strobes from the clockbox, one per decay-select value
//   dendrite   spike inputs, bit i weighted by w[i]
//   axon       registered spike output
//
// Build option
//   RETOSPECT_NEURON_INHIBIT_EN  when defined, weights are two's-complement
//   signed so synapses can be inhibitory; the sum is floored at 0. When
//   undefined, weights are unsigned. Chain length and order are unchanged.

module retospect_neuron_cell #(
   parameter int NUM_DENDRITES = 4,
   parameter int W_BITS        = 3,
   parameter int UT_BITS       = 6,
   parameter int SEL_BITS      = 3,
   parameter int REFRAC_BITS   = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       reset_nn,
   input  logic                       config_en,
   input  logic                       bs_in,
   output logic                       bs_out,
   input  logic [2**SEL_BITS-1:0]     clockbus,
   input  logic [NUM_DENDRITES-1:0]   dendrite,
   output logic                       axon
);

   localparam int CHAIN_LEN = NUM_DENDRITES*W_BITS + UT_BITS + SEL_BITS + REFRAC_BITS;
   localparam int ACC_W     = UT_BITS + $clog2(NUM_DENDRITES) + 2;
   localparam int DSEL_LSB  = REFRAC_BITS;
   localparam int THR_LSB   = REFRAC_BITS + SEL_BITS;

   // The whole chain is one shift register. w[0] sits at the MSB end next to
   // bs_in and the refractory field at the LSB end next to bs_out, so shifting
   // the whole vector right moves every field LSB into the next field's MSB.
   logic [CHAIN_LEN-1:0]   chain_q, chain_d;
   logic [UT_BITS-1:0]     ut_q, ut_d;
   logic [REFRAC_BITS-1:0] rcnt_q, rcnt_d;
   logic                   axon_q, axon_d;

   logic [W_BITS-1:0]      wRaw [NUM_DENDRITES];
   logic [UT_BITS-1:0]     thr;
   logic [SEL_BITS-1:0]    dsel;
   logic [REFRAC_BITS-1:0] refrac;
   logic [UT_BITS-1:0]     baseUt;
   logic [ACC_W-1:0]       wExt;
   logic [ACC_W-1:0]       acc;
   logic [UT_BITS-1:0]     sat;
   logic                   fire;

   // Field decode, weighted sum and saturation for the run path.
   always_comb begin
      wRaw   = '{default: '0};
      wExt   = '0;
      thr    = chain_q[THR_LSB +: UT_BITS];
      dsel   = chain_q[DSEL_LSB +: SEL_BITS];
      refrac = chain_q[0 +: REFRAC_BITS];
      baseUt = clockbus[dsel] ? (ut_q >> 1) : ut_q;
      acc    = {{(ACC_W-UT_BITS){1'b0}}, baseUt};
      for (int i = 0; i < NUM_DENDRITES; i++) begin
         wRaw[i] = chain_q[CHAIN_LEN-1-i*W_BITS -: W_BITS];
`ifdef RETOSPECT_NEURON_INHIBIT_EN
         wExt = {{(ACC_W-W_BITS){wRaw[i][W_BITS-1]}}, wRaw[i]};
`else
         wExt = {{(ACC_W-W_BITS){1'b0}}, wRaw[i]};
`endif
         if (dendrite[i]) begin
            acc = acc + wExt;
         end
      end
      // Two's-complement sign bit means the sum went negative; any set bit
      // above the membrane width means it overflowed the membrane range.
      if (acc[ACC_W-1]) begin
         sat = '0;
      end else if (|acc[ACC_W-2:UT_BITS]) begin
         sat = '1;
      end else begin
         sat = acc[UT_BITS-1:0];
      end
      fire = (sat >= thr);
   end

   // Next-state selection: network reset, then configuration shift, then
   // refractory countdown, then integrate-and-fire.
   always_comb begin
      chain_d = chain_q;
      ut_d    = ut_q;
      rcnt_d  = rcnt_q;
      axon_d  = 1'b0;
      if (reset_nn) begin
         ut_d   = '0;
         rcnt_d = '0;
      end else if (config_en) begin
         chain_d = {bs_in, chain_q[CHAIN_LEN-1:1]};
      end else if (rcnt_q != '0) begin
         rcnt_d = rcnt_q - 1'b1;
         ut_d   = '0;
      end else if (fire) begin
         axon_d = 1'b1;
         ut_d   = '0;
         rcnt_d = refrac;
      end else begin
         ut_d = sat;
      end
   end

   // State registers with synchronous full reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         chain_q <= '0;
         ut_q    <= '0;
         rcnt_q  <= '0;
         axon_q  <= 1'b0;
      end else begin
         chain_q <= chain_d;
         ut_q    <= ut_d;
         rcnt_q  <= rcnt_d;
         axon_q  <= axon_d;
      end
   end

   assign bs_out = chain_q[0];
   assign axon   = axon_q;

endmodule

// File: tb/tb_retospect_neuron_cell.sv
// tb_retospect_neuron_cell
// Self-checking bench for retospect_neuron_cell: directed scenarios followed
// by randomized traffic, all compared each cycle against a behavioural model
// that holds the chain as an array of bits and the neuron state as integers.

module tb_retospect_neuron_cell;

   localparam int N   = 4;
   localparam int WB  = 3;
   localparam int UTB = 6;
   localparam int SB  = 3;
   localparam int RB  = 2;
   localparam int L   = N*WB + UTB + SB + RB;
`ifdef RETOSPECT_NEURON_INHIBIT_EN
   localparam bit INHIBIT = 1'b1;
`else
   localparam bit INHIBIT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, reset_nn, config_en, bs_in;
   logic [7:0] clockbus;
   logic [3:0] dendrite;
   logic       bs_out, axon;

   int compared   = 0;
   int mismatched = 0;

   // Model: mb[0] is the bit next to bs_in, mb[L-1] drives bs_out.
   bit mb [L];
   int mUt   = 0;
   int mRcnt = 0;
   bit mAxon = 1'b0;

   retospect_neuron_cell dut (
      .clk       (clk),
      .reset     (reset),
      .reset_nn  (reset_nn),
      .config_en (config_en),
      .bs_in     (bs_in),
      .bs_out    (bs_out),
      .clockbus  (clockbus),
      .dendrite  (dendrite),
      .axon      (axon)
   );

   always #5 clk = ~clk;

   // Reads a field from the model chain, MSB first.
   function automatic int fieldVal(input int start, input int width, input bit isSigned);
      int v = 0;
      for (int k = 0; k < width; k++) v = v*2 + int'(mb[start+k]);
      if (isSigned && mb[start]) v = v - (1 << width);
      return v;
   endfunction

   // Advances the model by one clock edge using the currently driven inputs.
   task automatic modelStep();
      int thr, dsel, refr, acc;
      if (reset) begin
         for (int p = 0; p < L; p++) mb[p] = 1'b0;
         mUt = 0; mRcnt = 0; mAxon = 1'b0;
      end else if (reset_nn) begin
         mUt = 0; mRcnt = 0; mAxon = 1'b0;
      end else if (config_en) begin
         for (int p = L-1; p > 0; p--) mb[p] = mb[p-1];
         mb[0] = bs_in;
         mAxon = 1'b0;
      end else if (mRcnt != 0) begin
         mRcnt = mRcnt - 1; mUt = 0; mAxon = 1'b0;
      end else begin
         thr  = fieldVal(N*WB, UTB, 1'b0);
         dsel = fieldVal(N*WB + UTB, SB, 1'b0);
         refr = fieldVal(N*WB + UTB + SB, RB, 1'b0);
         acc  = clockbus[dsel] ? mUt / 2 : mUt;
         for (int i = 0; i < N; i++)
            if (dendrite[i]) acc = acc + fieldVal(i*WB, WB, INHIBIT);
         if (acc < 0) acc = 0;
         if (acc > (1 << UTB) - 1) acc = (1 << UTB) - 1;
         if (acc >= thr) begin
            mAxon = 1'b1; mUt = 0; mRcnt = refr;
         end else begin
            mAxon = 1'b0; mUt = acc;
         end
      end
   endtask

   task automatic checkValue(input string tag, input logic obs, input logic expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, expv);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkValue({tag, "_axon"}, axon, mAxon);
      checkValue({tag, "_bs_out"}, bs_out, mb[L-1]);
   endtask

   // Drives one cycle of inputs, clocks the DUT and model, checks #1 after.
   task automatic applyStimulus(input logic rst, input logic rnn, input logic cen,
                                input logic bin, input logic [7:0] cb,
                                input logic [3:0] den, input string tag);
      reset = rst; reset_nn = rnn; config_en = cen; bs_in = bin;
      clockbus = cb; dendrite = den;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput(tag);
   endtask

   // Shifts a full configuration in, refractory LSB first.
   task automatic loadConfig(input logic [2:0] w0, input logic [2:0] w1,
                             input logic [2:0] w2, input logic [2:0] w3,
                             input logic [5:0] thr, input logic [2:0] dsel,
                             input logic [1:0] refr);
      logic [L-1:0] cfg;
      cfg = {w0, w1, w2, w3, thr, dsel, refr};
      for (int k = 0; k < L; k++) applyStimulus(1'b0, 1'b0, 1'b1, cfg[k], 8'h00, 4'h0, "cfg");
   endtask

   initial begin
      logic pat [L];

      reset = 1'b1; reset_nn = 1'b0; config_en = 1'b0; bs_in = 1'b0;
      clockbus = '0; dendrite = '0;

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, "reset");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, "reset");
      checkValue("reset_axon", axon, 1'b0);
      checkValue("reset_bs_out", bs_out, 1'b0);

      for (int k = 0; k < L; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, "zeros");

      // Pattern replay: first shifted bit appears after the L-th shift.
      for (int k = 0; k < L; k++) begin
         pat[k] = 1'($urandom_range(0, 1));
         applyStimulus(1'b0, 1'b0, 1'b1, pat[k], 8'h00, 4'h0, "pattern");
      end
      checkValue("replay_0", bs_out, pat[0]);
      for (int j = 1; j < L; j++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, "flush");
         checkValue("replay", bs_out, pat[j]);
      end

      // w0=5, thr=12, no refractory: fires every 3rd edge.
      loadConfig(3'd5, 3'd0, 3'd0, 3'd0, 6'd12, 3'd0, 2'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, "rnn");
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h1, "period3");
         checkValue("period3_fire", axon, logic'(i % 3 == 0));
      end

      // Same with refractory 2: fires at edges 3, 8, 13.
      loadConfig(3'd5, 3'd0, 3'd0, 3'd0, 6'd12, 3'd0, 2'd2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, "rnn");
      for (int i = 1; i <= 13; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h1, "refrac");
         checkValue("refrac_fire", axon, logic'(i % 5 == 3));
      end

      // reset_nn mid-refractory, then weights must still integrate.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h1, "mid_refrac");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h1, "rnn_refrac");
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h1, "after_rnn");
         checkValue("after_rnn_fire", axon, logic'(i == 3));
      end

      // Saturation: all weights 7, threshold 63.
      loadConfig(3'd7, 3'd7, 3'd7, 3'd7, 6'd63, 3'd0, 2'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, "rnn");
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'hF, "saturate");
         checkValue("saturate_fire", axon, logic'(i == 3));
      end

      // w1 = 3'b111: +7 when unsigned, -1 (floored) when inhibitory.
      loadConfig(3'd0, 3'd7, 3'd0, 3'd0, 6'd7, 3'd0, 2'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, "rnn");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h2, "w111");
      checkValue("w111_fire", axon, logic'(!INHIBIT));

      // Randomized traffic: random configuration, then mixed run cycles.
      for (int blk = 0; blk < 15; blk++) begin
         loadConfig(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                    6'($urandom_range(0, 63)), 3'($urandom), 2'($urandom));
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0, "rnn");
         for (int c = 0; c < 120; c++) begin
            applyStimulus(logic'($urandom_range(0, 299) == 0),
                          logic'($urandom_range(0, 49) == 0),
                          logic'($urandom_range(0, 39) == 0),
                          1'($urandom), 8'($urandom), 4'($urandom), "random");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
